// File: rtl/edge_detection_top.sv
// Streaming 3x3 Sobel edge detector for VGA-timed RGB video; syncs/DE pass through a fixed delay.
// Optional macro EDGE_GRAYSCALE_MAG_EN: output the saturated magnitude as grey instead of thresholding.
module edge_detection_top #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_TOTAL   = 800,
    parameter int THRESHOLD = 64
) (
    input  logic        I_PCLK,
    input  logic        I_RST,
    input  logic        I_CLK_100,
    input  logic [23:0] I_PIX_DATA,
    input  logic        I_VSYNC,
    input  logic        I_HSYNC,
    input  logic        I_DE,
    output logic [23:0] O_PIX_DATA,
    output logic        O_VSYNC,
    output logic        O_HSYNC,
    output logic        O_DE,
    output logic        O_PCLK
);
    localparam int L  = H_TOTAL + 4;
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    assign O_PCLK = I_PCLK;

    logic unused_clk_100;
    assign unused_clk_100 = I_CLK_100;

    logic [XW-1:0] in_x;
    logic          in_vs_q;

    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            in_x    <= '0;
            in_vs_q <= 1'b0;
        end else begin
            in_vs_q <= I_VSYNC;
            if (I_VSYNC && !in_vs_q)
                in_x <= '0;
            else if (I_DE)
                in_x <= (in_x == XW'(H_ACTIVE - 1)) ? '0 : in_x + 1'b1;
        end
    end

    logic [9:0] luma_sum;
    logic [7:0] luma;
    assign luma_sum = {2'b0, I_PIX_DATA[23:16]} + {1'b0, I_PIX_DATA[15:8], 1'b0} + {2'b0, I_PIX_DATA[7:0]};
    assign luma     = luma_sum[9:2];

    // lb0 holds the previous line, lb1 the line before it; both advance only on DE.
    logic [7:0] lb0 [H_ACTIVE];
    logic [7:0] lb1 [H_ACTIVE];
    logic [7:0] lb0_rd, lb1_rd;
    assign lb0_rd = lb0[in_x];
    assign lb1_rd = lb1[in_x];

    always_ff @(posedge I_PCLK) begin
        if (I_DE) begin
            lb0[in_x] <= luma;
            lb1[in_x] <= lb0_rd;
        end
    end

    logic [2:0][2:0][7:0] win;

    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            win <= '0;
        end else if (I_DE) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= luma;
        end
    end

    logic [9:0]         gx_p, gx_n, gy_p, gy_n;
    logic signed [10:0] gx, gy;
    assign gx_p = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b0, win[2][2]};
    assign gx_n = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b0, win[2][0]};
    assign gy_p = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b0, win[2][2]};
    assign gy_n = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b0, win[0][2]};

    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            gx <= '0;
            gy <= '0;
        end else begin
            gx <= $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
            gy <= $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
        end
    end

    logic [10:0] ax, ay;
    logic [11:0] mag;
    logic [7:0]  mag_sat;
    assign ax      = gx[10] ? 11'(-gx) : 11'(gx);
    assign ay      = gy[10] ? 11'(-gy) : 11'(gy);
    assign mag     = {1'b0, ax} + {1'b0, ay};
    assign mag_sat = (mag > 12'd255) ? 8'hFF : mag[7:0];

    logic [L-1:0][2:0] dly_pipe;

    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) dly_pipe <= '0;
        else       dly_pipe <= {dly_pipe[L-2:0], {I_VSYNC, I_HSYNC, I_DE}};
    end

    assign {O_VSYNC, O_HSYNC, O_DE} = dly_pipe[L-1];

    // The tap one stage before the output describes the pixel being registered this cycle.
    logic tap_vs, tap_de;
    assign tap_vs = dly_pipe[L-2][2];
    assign tap_de = dly_pipe[L-2][0];

    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_vs_q, synced;

    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) begin
            out_x    <= '0;
            out_y    <= '0;
            out_vs_q <= 1'b0;
            synced   <= 1'b0;
        end else begin
            out_vs_q <= tap_vs;
            if (tap_vs && !out_vs_q) begin
                out_x  <= '0;
                out_y  <= '0;
                synced <= 1'b1;
            end else if (tap_de) begin
                if (out_x == XW'(H_ACTIVE - 1)) begin
                    out_x <= '0;
                    out_y <= (out_y == YW'(V_ACTIVE - 1)) ? '0 : out_y + 1'b1;
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end
        end
    end

    logic        border;
    logic [23:0] pix_next;
    assign border = (out_x == '0) || (out_x == XW'(H_ACTIVE - 1)) ||
                    (out_y == '0) || (out_y == YW'(V_ACTIVE - 1));

    always_comb begin
        pix_next = '0;
`ifdef EDGE_GRAYSCALE_MAG_EN
        pix_next = {3{mag_sat}};
`else
        if (mag_sat >= 8'(THRESHOLD)) pix_next = 24'hFFFFFF;
`endif
        if (!tap_de || border || !synced) pix_next = '0;
    end

    always_ff @(posedge I_PCLK or posedge I_RST) begin
        if (I_RST) O_PIX_DATA <= '0;
        else       O_PIX_DATA <= pix_next;
    end
endmodule

// File: tb/tb_edge_detection_top.sv
// Scoreboard bench for edge_detection_top on a reduced frame (16x8 active, 24 clocks/line).
`timescale 1ns/1ps
module tb_edge_detection_top;
    localparam int H   = 16;
    localparam int V   = 8;
    localparam int HT  = 24;
    localparam int THR = 64;
    localparam int VT  = V + 3;   // line 0 vsync, line 1 back porch, V active, 1 front porch
    localparam int L   = HT + 4;

    logic        pclk, clk100, rst;
    logic [23:0] pix;
    logic        vs, hs, de;
    logic [23:0] O_PIX_DATA;
    logic        O_VSYNC, O_HSYNC, O_DE, O_PCLK;

    edge_detection_top #(.H_ACTIVE(H), .V_ACTIVE(V), .H_TOTAL(HT), .THRESHOLD(THR)) dut (
        .I_PCLK(pclk), .I_RST(rst), .I_CLK_100(clk100),
        .I_PIX_DATA(pix), .I_VSYNC(vs), .I_HSYNC(hs), .I_DE(de),
        .O_PIX_DATA(O_PIX_DATA), .O_VSYNC(O_VSYNC), .O_HSYNC(O_HSYNC), .O_DE(O_DE),
        .O_PCLK(O_PCLK)
    );

    initial begin pclk = 0; forever #5 pclk = ~pclk; end
    initial begin clk100 = 0; forever #2 clk100 = ~clk100; end

    int total = 0;
    int bad   = 0;

    logic [23:0] img [V][H];
    logic [23:0] sb_q [$];
    logic        post_rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int luma(input logic [23:0] p);
        return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
    endfunction

    // Reference Sobel over the stored frame, used for the noise frames.
    function automatic logic [23:0] model_px(input int x, input int y);
        int w [3][3];
        int gx, gy, m;
        if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return 24'h0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = luma(img[y - 1 + r][x - 1 + c]);
        gx = (w[0][2] + 2 * w[1][2] + w[2][2]) - (w[0][0] + 2 * w[1][0] + w[2][0]);
        gy = (w[2][0] + 2 * w[2][1] + w[2][2]) - (w[0][0] + 2 * w[0][1] + w[0][2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        return (m >= THR) ? 24'hFFFFFF : 24'h0;
    endfunction

    // kind 0: uniform grey, kind 1: vertical step at H/2, kind 2: noise
    function automatic logic [23:0] expect_px(input int kind, input int x, input int y);
        if (kind == 0) return 24'h0;
        if (kind == 1)
            return (y > 0 && y < V - 1 && (x == H / 2 - 1 || x == H / 2)) ? 24'hFFFFFF : 24'h0;
        return model_px(x, y);
    endfunction

    task automatic fill_frame(input int kind);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                if (kind == 0)      img[y][x] = 24'h808080;
                else if (kind == 1) img[y][x] = (x >= H / 2) ? 24'hFFFFFF : 24'h000000;
                else                img[y][x] = 24'($urandom());
    endtask

    task automatic send_frame(input int kind, input int rst_line, input int rst_col);
        int rst_left;
        rst_left = 0;
        post_rst = 1'b0;
        for (int l = 0; l < VT; l++) begin
            for (int c = 0; c < HT; c++) begin
                @(negedge pclk);
                if (l == rst_line && c == rst_col) begin
                    rst = 1'b1;
                    rst_left = 3;
                    sb_q.delete();
                    post_rst = 1'b1;
                    #1;
                    check("async_rst_pix", 32'(O_PIX_DATA), 32'h0);
                    check("async_rst_sync", 32'({O_VSYNC, O_HSYNC, O_DE}), 32'h0);
                end else if (rst_left > 0) begin
                    rst_left--;
                    if (rst_left == 0) rst = 1'b0;
                end
                vs  = (l == 0);
                hs  = (c >= H + 2 && c < H + 5);
                de  = (l >= 2 && l < V + 2 && c < H);
                pix = 24'h0;
                if (de) pix = img[l - 2][c];
                if (de && !rst) sb_q.push_back(post_rst ? 24'h0 : expect_px(kind, c, l - 2));
            end
        end
    endtask

    // Monitor: sync/DE delay check every cycle, pixel scoreboard whenever O_DE is high.
    logic [2:0]  log_mem [4096];
    int          ec = 0;
    int          valid_from = 0;
    int          first_ide = -1;
    int          first_ode = -1;
    int          mon_idx;
    logic [2:0]  mon_exp;
    logic [23:0] mon_px;

    always begin
        @(posedge pclk);
        if (de && first_ide < 0) first_ide = ec;
        log_mem[ec % 4096] = {vs, hs, de};
        if (rst) valid_from = ec + 1;
        ec++;
        #1;
        mon_idx = ec - L;
        mon_exp = (mon_idx >= 0 && mon_idx >= valid_from) ? log_mem[mon_idx % 4096] : 3'b000;
        check("sync_delay", 32'({O_VSYNC, O_HSYNC, O_DE}), 32'(mon_exp));
        if (O_DE) begin
            if (first_ode < 0) first_ode = ec;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got %h with no expected pixel queued", O_PIX_DATA);
            end else begin
                mon_px = sb_q.pop_front();
                check("pix", 32'(O_PIX_DATA), 32'(mon_px));
            end
        end else begin
            check("blank_pix", 32'(O_PIX_DATA), 32'h0);
        end
    end

    initial begin
        rst = 1'b1; pix = '0; vs = 0; hs = 0; de = 0;
        post_rst = 1'b0;
        #1;
        check("reset_pix", 32'(O_PIX_DATA), 32'h0);
        check("reset_sync", 32'({O_VSYNC, O_HSYNC, O_DE}), 32'h0);
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        repeat (5) @(negedge pclk);

        fill_frame(0); send_frame(0, -1, -1);
        fill_frame(1); send_frame(1, -1, -1);
        fill_frame(2); send_frame(2, -1, -1);
        fill_frame(2); send_frame(2, 6, 5);     // reset mid active row 4
        fill_frame(1); send_frame(1, -1, -1);   // recovery after reset
        fill_frame(2); send_frame(2, -1, -1);

        @(negedge pclk);
        vs = 0; hs = 0; de = 0; pix = '0;
        repeat (2 * HT) @(negedge pclk);
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        check("latency", 32'(first_ode - first_ide), 32'(L));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edge_detection_top.md
Name: edge_detection_top

Overview:
Streaming Sobel edge detector on a VGA-timed RGB pixel stream (640x480 active, 800 clocks per line). Each pixel is converted to 8-bit luma and held in two line buffers. A 3x3 Sobel operator produces a gradient magnitude, which is thresholded to a black/white pixel. It sits between the video input interface and the video output interface. Syncs and DE pass through with a fixed delay, so output framing is identical to input framing.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- H_TOTAL, 800: pixel clocks per line including blanking. Sets the sync/DE delay.
- THRESHOLD, 64: 8-bit edge threshold applied to the saturated magnitude.

Ports:
- I_PCLK, input, 1: the single clock for all logic (pixel clock, 25.175 MHz). Rising edge.
- I_RST, input, 1: asynchronous, active-high reset.
- I_CLK_100, input, 1: reserved core-clock input. No logic is clocked by it.
- I_PIX_DATA, input, 24: RGB pixel, {R[23:16], G[15:8], B[7:0]}. Valid when I_DE=1.
- I_VSYNC, input, 1: vertical sync, active-high.
- I_HSYNC, input, 1: horizontal sync, active-high.
- I_DE, input, 1: data enable.
- O_PIX_DATA, output, 24: edge pixel, registered.
- O_VSYNC, output, 1: I_VSYNC delayed.
- O_HSYNC, output, 1: I_HSYNC delayed.
- O_DE, output, 1: I_DE delayed.
- O_PCLK, output, 1: I_PCLK forwarded combinationally.

Behaviour:
- Reset values: O_PIX_DATA=0, O_VSYNC=0, O_HSYNC=0, O_DE=0. The sync/DE delay line, window registers and counters are also cleared. Line-buffer RAM contents are not cleared.
- Latency: O_VSYNC, O_HSYNC and O_DE equal the corresponding inputs delayed by exactly L = H_TOTAL+4 clocks, implemented as a 3-bit-wide delay line of depth L.
- O_PIX_DATA is aligned with O_DE.
- Input position: x increments on each I_DE=1 clock. At x=H_ACTIVE-1 it wraps to 0 and y increments. A rising edge of I_VSYNC clears both x and y.
- Output position: the output x/y counters follow the same rules, driven by the delayed DE/VSYNC.
- Luma: Y = (R + 2G + B) >> 2, computed with a 10-bit sum and truncated to 8 bits.
- Line buffers: two buffers of H_ACTIVE x 8 bits, written/shifted only on I_DE=1. Together with the current pixel they form a 3x3 window; the window centred at (x,y) is complete when input pixel (x+1,y+1) arrives.
- Window stage: 1 registered stage.
- Sobel stage (1 registered stage), with p[row][col] and col 0 = left:
  - Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20)
  - Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02)
  - Both 11-bit signed.
- Magnitude stage (1 registered stage): M = |Gx| + |Gy| (12-bit), saturated to 255.
- Edge output: M >= THRESHOLD gives 24'hFFFFFF, otherwise 24'h000000.
- Borders: output pixels with x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 are forced to 24'h000000.
- Blanking: O_PIX_DATA=0 whenever O_DE=0.
- Reset deasserted mid-frame: O_PIX_DATA is forced to 0 until the first rising edge of the delayed VSYNC. Syncs/DE resume following the inputs after L clocks.
- I_DE held low for a whole line: the line buffers do not advance. Pixel data only moves on DE.
- Arithmetic: all values unsigned except Gx/Gy. No overflow is possible at the stated widths.

Optional Feature:
- Macro: EDGE_GRAYSCALE_MAG_EN.
- Defined: O_PIX_DATA = {M, M, M}, the saturated magnitude on all three channels. THRESHOLD is ignored. Border and blanking zeroing still apply.
- Undefined: binary thresholded output as described above.

Test Plan:
- Uniform frame, every pixel 24'h808080 -> every O_PIX_DATA = 0 for the whole frame.
- Vertical step (cols 0..319 = 0, cols 320..639 = 24'hFFFFFF):
  - Columns 319 and 320, rows 1..478 -> 24'hFFFFFF (|Gx| = 1020, saturated).
  - All other pixels -> 0.
- Latency: O_DE first rises exactly H_TOTAL+4 = 804 clocks after I_DE first rises. O_HSYNC/O_VSYNC patterns are bit-identical to the inputs with the same shift.
- Border: random-noise frame -> row 0, row 479, column 0 and column 639 are all 0. O_PIX_DATA = 0 whenever O_DE = 0.
- Reset: assert I_RST for 3 clocks mid-line 200 -> all outputs 0 immediately (asynchronous). After release, O_PIX_DATA stays 0 until the delayed VSYNC rises, then the next frame is correct.
- With EDGE_GRAYSCALE_MAG_EN and a horizontal step from 0 to 24'h101010 (Y = 16): edge rows give Gy = 64 -> output 24'h404040. Flat regions give 0.
